// File: rtl/sim_tick_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : sim_tick_pkg
//  Purpose  : Shared state encoding and default constants for the
//             sim_tick_bridge co-simulation stepping bridge.
//  Revision : 1.0  initial release
// ============================================================================
package sim_tick_pkg;

    // Bridge sequencing states
    typedef enum logic [2:0] {
        S_RST  = 3'd0,
        S_CAP  = 3'd1,
        S_SEND = 3'd2,
        S_WAIT = 3'd3,
        S_STEP = 3'd4,
        S_DONE = 3'd5
    } state_t;

    localparam int DEF_NUM_CHANNELS   = 4;
    localparam int DEF_FWD_W          = 128;
    localparam int DEF_REV_W          = 128;
    localparam int DEF_PIPE_DEPTH     = 1;
    localparam int DEF_RESET_CYCLES   = 10;
    localparam int DEF_TIMEOUT_CYCLES = 1000000;

    // Width of the optional WAIT-state watchdog counter
    localparam int TIMEOUT_W = 32;

endpackage : sim_tick_pkg
`default_nettype wire

// File: rtl/sim_tick_delay_line.sv
`default_nettype none
// ============================================================================
//  Module   : sim_tick_delay_line
//  Purpose  : Delays host response records by PIPE_DEPTH pushes before they
//             reach the DUT. Each entry carries the channel mask captured at
//             push time; masked-off channels leave the output slice untouched
//             when that entry emerges. Entries before the first PIPE_DEPTH
//             pushes are all-zero with an all-zero mask.
//  Revision : 1.0  initial release
// ============================================================================
module sim_tick_delay_line #(
    parameter int NUM_CHANNELS = 4,
    parameter int W            = 128,
    parameter int PIPE_DEPTH   = 1
) (
    input  logic                      clk_i,
    input  logic                      rst_ni,
    input  logic                      push_i,
    input  logic [NUM_CHANNELS-1:0]   mask_i,
    input  logic [NUM_CHANNELS*W-1:0] data_i,
    output logic [NUM_CHANNELS*W-1:0] data_o
);

    localparam int DW = NUM_CHANNELS * W;

    logic [DW-1:0]           out_q;
    logic [DW-1:0]           src_d;
    logic [NUM_CHANNELS-1:0] src_mask_d;

    generate
        if (PIPE_DEPTH == 0) begin : g_direct
            // Zero depth: the response being pushed goes straight to the output
            always_comb begin
                src_d      = data_i;
                src_mask_d = mask_i;
            end
        end else begin : g_pipe
            logic [DW-1:0]           stage_q [PIPE_DEPTH];
            logic [NUM_CHANNELS-1:0] smask_q [PIPE_DEPTH];

            // Shift register of pending responses, advanced once per push
            always_ff @(posedge clk_i or negedge rst_ni) begin
                if (!rst_ni) begin
                    for (int i = 0; i < PIPE_DEPTH; i++) begin
                        stage_q[i] <= '0;
                        smask_q[i] <= '0;
                    end
                end else if (push_i) begin
                    stage_q[0] <= data_i;
                    smask_q[0] <= mask_i;
                    for (int i = 1; i < PIPE_DEPTH; i++) begin
                        stage_q[i] <= stage_q[i-1];
                        smask_q[i] <= smask_q[i-1];
                    end
                end
            end

            // The oldest entry is the one released to the DUT on this push
            always_comb begin
                src_d      = stage_q[PIPE_DEPTH-1];
                src_mask_d = smask_q[PIPE_DEPTH-1];
            end
        end
    endgenerate

    // Output register: per-channel merge of the released entry
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            out_q <= '0;
        end else if (push_i) begin
            for (int c = 0; c < NUM_CHANNELS; c++) begin
                if (src_mask_d[c]) begin
                    out_q[c*W +: W] <= src_d[c*W +: W];
                end
            end
        end
    end

    assign data_o = out_q;

endmodule : sim_tick_delay_line
`default_nettype wire

// File: rtl/sim_tick_bridge.sv
`default_nettype none
// ============================================================================
//  Module   : sim_tick_bridge
//  Purpose  : Lock-step bridge between a clock-enabled DUT and a host
//             simulator. Each step snapshots the DUT records, hands them to
//             the host, waits for the host response, feeds it (optionally
//             delayed) back to the DUT and advances the DUT by one cycle.
//  Options  : SIM_TICK_BRIDGE_TIMEOUT_EN adds a WAIT-state watchdog with a
//             sticky 'timeout' output and TIMEOUT_CYCLES parameter.
//  Revision : 1.0  initial release
// ============================================================================
module sim_tick_bridge
    import sim_tick_pkg::*;
#(
    parameter int NUM_CHANNELS = DEF_NUM_CHANNELS,
    parameter int FWD_W        = DEF_FWD_W,
    parameter int REV_W        = DEF_REV_W,
    parameter int PIPE_DEPTH   = DEF_PIPE_DEPTH,
    parameter int RESET_CYCLES = DEF_RESET_CYCLES
`ifdef SIM_TICK_BRIDGE_TIMEOUT_EN
    ,
    parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES
`endif
) (
    input  logic                          clock,
    input  logic                          reset_n,
    input  logic [NUM_CHANNELS*FWD_W-1:0] dut_out,
    output logic [NUM_CHANNELS*REV_W-1:0] dut_in,
    output logic                          dut_clk_en,
    output logic                          dut_reset,
    output logic                          host_req_valid,
    input  logic                          host_req_ready,
    output logic [NUM_CHANNELS*FWD_W-1:0] host_req_data,
    input  logic                          host_rsp_valid,
    output logic                          host_rsp_ready,
    input  logic [NUM_CHANNELS*REV_W-1:0] host_rsp_data,
    input  logic                          host_fin,
    input  logic [NUM_CHANNELS-1:0]       chan_mask,
    output logic                          fin,
    output logic [63:0]                   cycle_count
`ifdef SIM_TICK_BRIDGE_TIMEOUT_EN
    ,
    output logic                          timeout
`endif
);

    localparam logic [7:0] RST_LAST = 8'(RESET_CYCLES);

    state_t                        state_q;
    logic [7:0]                    rst_cnt_q;
    logic [7:0]                    rst_cnt_d;
    logic [NUM_CHANNELS*FWD_W-1:0] snap_q;
    logic [63:0]                   cycle_count_q;
    logic [63:0]                   cycle_count_d;
    logic                          fin_q;
    logic                          req_valid_q;
    logic                          rsp_ready_q;
    logic                          dut_reset_q;
    logic                          clk_en_q;
    logic                          push;
    logic                          wd_expire;

    // Counter increments kept apart from the state register
    always_comb begin
        rst_cnt_d     = rst_cnt_q + 8'd1;
        cycle_count_d = cycle_count_q + 64'd1;
    end

    // A non-final response accepted in WAIT enters the delay line
    assign push = (state_q == S_WAIT) && host_rsp_valid && !host_fin;

`ifdef SIM_TICK_BRIDGE_TIMEOUT_EN
    localparam logic [TIMEOUT_W-1:0] WD_LAST = TIMEOUT_W'(TIMEOUT_CYCLES - 1);

    logic [TIMEOUT_W-1:0] wd_cnt_q;
    logic [TIMEOUT_W-1:0] wd_cnt_d;
    logic                 timeout_q;

    always_comb wd_cnt_d = wd_cnt_q + TIMEOUT_W'(1);

    // Expiry fires on the last permitted WAIT cycle
    assign wd_expire = (state_q == S_WAIT) && (wd_cnt_q == WD_LAST);

    // Watchdog counts WAIT cycles; timeout flag is sticky until reset
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            wd_cnt_q  <= '0;
            timeout_q <= 1'b0;
        end else begin
            wd_cnt_q <= (state_q == S_WAIT) ? wd_cnt_d : '0;
            if (wd_expire && !host_rsp_valid) begin
                timeout_q <= 1'b1;
            end
        end
    end

    assign timeout = timeout_q;
`else
    assign wd_expire = 1'b0;
`endif

    // Sequencer: state and all handshake/DUT-control outputs are registered
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q       <= S_RST;
            rst_cnt_q     <= '0;
            snap_q        <= '0;
            cycle_count_q <= '0;
            fin_q         <= 1'b0;
            req_valid_q   <= 1'b0;
            rsp_ready_q   <= 1'b0;
            dut_reset_q   <= 1'b1;
            clk_en_q      <= 1'b0;
        end else begin
            case (state_q)
                S_RST: begin
                    if (rst_cnt_q == RST_LAST) begin
                        state_q     <= S_CAP;
                        dut_reset_q <= 1'b0;
                        clk_en_q    <= 1'b0;
                    end else begin
                        rst_cnt_q   <= rst_cnt_d;
                        dut_reset_q <= 1'b1;
                        clk_en_q    <= 1'b1;
                    end
                end
                S_CAP: begin
                    snap_q      <= dut_out;
                    req_valid_q <= 1'b1;
                    state_q     <= S_SEND;
                end
                S_SEND: begin
                    if (host_req_ready) begin
                        req_valid_q <= 1'b0;
                        rsp_ready_q <= 1'b1;
                        state_q     <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (host_rsp_valid) begin
                        rsp_ready_q <= 1'b0;
                        if (host_fin) begin
                            fin_q   <= 1'b1;
                            state_q <= S_DONE;
                        end else begin
                            clk_en_q <= 1'b1;
                            state_q  <= S_STEP;
                        end
                    end else if (wd_expire) begin
                        rsp_ready_q <= 1'b0;
                        fin_q       <= 1'b1;
                        state_q     <= S_DONE;
                    end
                end
                S_STEP: begin
                    clk_en_q      <= 1'b0;
                    cycle_count_q <= cycle_count_d;
                    state_q       <= S_CAP;
                end
                S_DONE: begin
                    state_q <= S_DONE;
                end
                default: begin
                    state_q <= S_RST;
                end
            endcase
        end
    end

    sim_tick_delay_line #(
        .NUM_CHANNELS (NUM_CHANNELS),
        .W            (REV_W),
        .PIPE_DEPTH   (PIPE_DEPTH)
    ) u_delay_line (
        .clk_i  (clock),
        .rst_ni (reset_n),
        .push_i (push),
        .mask_i (chan_mask),
        .data_i (host_rsp_data),
        .data_o (dut_in)
    );

    assign host_req_data  = snap_q;
    assign host_req_valid = req_valid_q;
    assign host_rsp_ready = rsp_ready_q;
    assign dut_clk_en     = clk_en_q;
    assign dut_reset      = dut_reset_q;
    assign fin            = fin_q;
    assign cycle_count    = cycle_count_q;

endmodule : sim_tick_bridge
`default_nettype wire

// File: doc/sim_tick_bridge.md
SIM_TICK_BRIDGE -- requirements
Module: sim_tick_bridge

Interface
REQ-001 SHALL have parameter NUM_CHANNELS, default 4, meaning the number of record channels (1..8).
REQ-002 SHALL have parameter FWD_W, default 128, meaning the bits per channel of the DUT-to-host record.
REQ-003 SHALL have parameter REV_W, default 128, meaning the bits per channel of the host-to-DUT record.
REQ-004 SHALL have parameter PIPE_DEPTH, default 1, meaning the number of DUT steps a host response is delayed (0..3).
REQ-005 SHALL have parameter RESET_CYCLES, default 10, meaning the number of DUT cycles held in reset (1..255).
REQ-006 SHALL have ports: clock in 1, the single clock; reset_n in 1, asynchronous active-low reset.
REQ-007 SHALL have ports: dut_out in NUM_CHANNELS*FWD_W, DUT records; dut_in out NUM_CHANNELS*REV_W, records to the DUT.
REQ-008 SHALL have ports: dut_clk_en out 1, DUT advance enable; dut_reset out 1, DUT reset.
REQ-009 SHALL have ports: host_req_valid out 1; host_req_ready in 1; host_req_data out NUM_CHANNELS*FWD_W.
REQ-010 SHALL have ports: host_rsp_valid in 1; host_rsp_ready out 1; host_rsp_data in NUM_CHANNELS*REV_W; host_fin in 1.
REQ-011 SHALL have ports: chan_mask in NUM_CHANNELS, channel update enable; fin out 1; cycle_count out 64.

Function
REQ-012 SHALL implement states RST, CAP, SEND, WAIT, STEP and DONE.
REQ-013 RST SHALL drive dut_reset=1 and dut_clk_en=1 for exactly RESET_CYCLES cycles, then go to CAP.
REQ-014 CAP SHALL last one cycle, load the snapshot register from dut_out and go to SEND.
REQ-015 SEND SHALL hold host_req_valid=1 with host_req_data equal to the snapshot, stable until host_req_ready, then go to WAIT.
REQ-016 WAIT SHALL hold host_rsp_ready=1; host_rsp_valid with host_fin=0 SHALL go to STEP, and with host_fin=1 SHALL go to DONE.
REQ-017 A WAIT to STEP transition SHALL push host_rsp_data into the delay line, and dut_in SHALL update at the STEP entry edge.
REQ-018 STEP SHALL assert dut_clk_en for exactly one cycle, increment cycle_count by 1 with 64-bit wrap, and go to CAP.
REQ-019 With PIPE_DEPTH=0, dut_in SHALL take the current response; with PIPE_DEPTH=N, it SHALL take the response accepted N steps earlier, and all-zero before N responses exist.
REQ-020 A channel whose chan_mask bit is 0 at push time SHALL keep its previous dut_in slice and discard its response slice.
REQ-021 DONE SHALL hold fin=1, keep dut_clk_en, valid and ready outputs at 0, and leave only on reset.
REQ-022 host_req_valid and host_rsp_ready SHALL never be asserted in the same cycle.
REQ-023 dut_clk_en SHALL be 0 in CAP, SEND, WAIT and DONE.

Reset
REQ-024 Assertion of reset_n SHALL immediately force state RST, the RST counter to 0, snapshot, delay line, dut_in and cycle_count to 0, fin=0, valid/ready outputs to 0, dut_reset=1 and dut_clk_en=0.
REQ-025 Reset asserted mid-handshake SHALL abort the handshake with no partial delay-line update.

Configuration
REQ-026 With SIM_TICK_BRIDGE_TIMEOUT_EN defined, a 32-bit watchdog SHALL count cycles in WAIT, clear on leaving WAIT, and on reaching TIMEOUT_CYCLES (parameter, default 1000000) SHALL set output timeout=1 sticky and go to DONE.
REQ-027 Without SIM_TICK_BRIDGE_TIMEOUT_EN, the timeout port, the watchdog and TIMEOUT_CYCLES SHALL be absent, and WAIT SHALL wait indefinitely.

Structure
REQ-028 Package sim_tick_pkg SHALL hold the state enum, the default parameter constants and the timeout width constant.
REQ-029 The delay line SHALL be sub-module sim_tick_delay_line, parametrised by width and PIPE_DEPTH, with push enable and per-channel mask.

Verification
REQ-030 Reset release with RESET_CYCLES=10 -> dut_reset high for exactly 10 clocks with dut_clk_en high, then host_req_valid rises 2 cycles later.
REQ-031 host_req_ready held 0 for 5 cycles -> host_req_data is stable and dut_clk_en is 0 throughout.
REQ-032 PIPE_DEPTH=1, responses A, B, C -> dut_in is 0, A, B at steps 1, 2, 3, and cycle_count is 3.
REQ-033 chan_mask=4'b1011 and a response with channel 2 = 0xFF -> dut_in channel 2 is unchanged and the other channels are updated.
REQ-034 host_rsp_valid with host_fin=1 -> fin=1 on the next cycle, with no further dut_clk_en or requests.
REQ-035 With TIMEOUT_EN defined and TIMEOUT_CYCLES=16, no response -> timeout=1 and fin=1 after 16 WAIT cycles; reset_n pulse -> both clear.
